sprite_scheduler: RTL and testbench
===================================

SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 4, meaning the number of sprite slots; slot 0 is the doodler, higher slots are platforms.
REQ-002 SHALL have parameter COORD_W, default 10, meaning the screen coordinate width.
REQ-003 SHALL have port Clk, input, 1, the single system clock.
REQ-004 SHALL have port Reset, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port frame_start, input, 1, a one-cycle pulse at vblank entry.
REQ-006 SHALL have port vblank, input, 1, high during vertical blank.
REQ-007 SHALL have port upd_valid, input, 1, sprite update request.
REQ-008 SHALL have port upd_ready, output, 1, update accepted this cycle when high with upd_valid.
REQ-009 SHALL have port upd_id, input, log2(NUM_SPRITES), the slot to update.
REQ-010 SHALL have ports upd_x, upd_y and upd_size, input, COORD_W each: sprite centre and half-size.
REQ-011 SHALL have port upd_en, input, 1, slot visible.
REQ-012 SHALL have ports DrawX and DrawY, input, COORD_W each, the current pixel from the VGA controller.
REQ-013 SHALL have port pix_valid, input, 1, DrawX/DrawY valid this cycle.
REQ-014 SHALL have port out_valid, output, 1, the pipelined copy of pix_valid.
REQ-015 SHALL have port hit, output, 1, the pixel lies inside an enabled sprite.
REQ-016 SHALL have port hit_id, output, log2(NUM_SPRITES), the winning slot.
REQ-017 SHALL have ports OffX and OffY, output, COORD_W each, the pixel offset from the winning sprite's top-left corner.

Function
REQ-018 SHALL implement FSM states IDLE, UPDATE and DISPLAY.
REQ-019 SHALL transition IDLE->UPDATE and DISPLAY->UPDATE on frame_start; frame_start in UPDATE is ignored.
REQ-020 SHALL transition UPDATE->DISPLAY in the first UPDATE cycle with vblank=0.
REQ-021 SHALL drive upd_ready = (state==UPDATE) && vblank, combinationally from state.
REQ-022 SHALL write an accepted update (upd_valid && upd_ready) to the shadow bank slot upd_id; repeated writes to one slot in a frame SHALL be last-write-wins.
REQ-023 SHALL copy the shadow bank to the active bank on the UPDATE->DISPLAY transition cycle only; the active bank is constant during DISPLAY.
REQ-024 SHALL compute the box test from the active bank, with edges inclusive: X-size <= DrawX <= X+size, and the same for Y.
REQ-025 SHALL evaluate bounds at COORD_W+1 bits with no wrap; X<size saturates the low bound at 0.
REQ-026 SHALL resolve overlapping sprites so that the lowest slot index wins (doodler on top).
REQ-027 SHALL compute OffX = DrawX - max(X-size, 0) and OffY likewise, truncated to COORD_W bits.
REQ-028 SHALL have a pipeline latency of 2 cycles.
REQ-029 SHALL use pipeline stage 1 to register the pixel and the per-slot in-box vector, and stage 2 to register the priority-encoded outputs.
REQ-030 SHALL hold hit=0, hit_id=0 and OffX=OffY=0 when out_valid=0 or when no enabled slot matches.
REQ-031 SHALL keep the pixel pipeline running in all states, including IDLE, using the active bank.

Reset
REQ-032 SHALL, on Reset low, immediately force state IDLE, upd_ready=0, out_valid=0, hit=0, hit_id=0, OffX=OffY=0, all shadow and active slots zeroed, and all slots disabled.
REQ-033 SHALL discard any update, pending commit or in-flight pixel on reset mid-operation; no commit occurs.
REQ-034 SHALL leave state IDLE on the first frame_start after Reset is released.

Structure
REQ-035 SHALL place the state enum, sprite record typedef (x, y, size, en), NUM_SPRITES and COORD_W defaults in shared package game_pkg.
REQ-036 SHALL instantiate one sub-module, sprite_box_test, per slot: a combinational in-box test plus offset calculation.

Verification
REQ-037 SHALL cover: reset, frame_start, vblank=1, write slot0 x=100 y=200 size=8 en=1, vblank=0, then pixel (92,192) -> 2 cycles later hit=1, hit_id=0, OffX=0, OffY=0; pixel (109,200) -> hit=0.
REQ-038 SHALL cover: slot0 (100,100,8) and slot2 (104,104,8) enabled, pixel (106,106) -> hit_id=0, OffX=14, OffY=14.
REQ-039 SHALL cover: slot1 x=3 size=8 y=50, pixel (0,50) -> hit=1, OffX=0, with no wrap to 1019.
REQ-040 SHALL cover: upd_valid asserted during DISPLAY -> upd_ready=0 and the active bank is unchanged; two writes to slot1 in one UPDATE window -> the second takes effect after vblank falls.
REQ-041 SHALL cover: Reset low while in UPDATE with a pending write -> outputs zero at once, all slots disabled after release, and no hit until the next frame_start/commit cycle.
REQ-042 SHALL cover: pix_valid toggling 1,0,1 -> out_valid reproduces 1,0,1 delayed by exactly 2 cycles.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the sprite scheduler:
//   - default slot count and screen coordinate width
//   - scheduler FSM state encoding (enum plus plain localparam constants)
//   - sprite record layout (x, y, size, en) at the default coordinate width
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int NUM_SPRITES_DEF = 4;
    localparam int COORD_W_DEF     = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UPDATE  = 2'd1,
        DISPLAY = 2'd2
    } state_e;

    // Plain constants so state flops can stay logic-typed.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_UPDATE  = 2'd1;
    localparam logic [1:0] ST_DISPLAY = 2'd2;

    // Sprite record: centre (x, y), half-size, visible flag.
    typedef struct packed {
        logic [COORD_W_DEF-1:0] x;
        logic [COORD_W_DEF-1:0] y;
        logic [COORD_W_DEF-1:0] size;
        logic                   en;
    } sprite_t;

endpackage

// File: rtl/sprite_box_test.sv
// ---------------------------------------------------------------------------
// sprite_box_test
// Combinational in-box test of one pixel against one sprite slot, plus the
// pixel offset from the sprite's top-left corner.
// Ports:
//   x, y, size  : sprite centre and half-size
//   en          : slot visible
//   px, py      : pixel under test
//   in_box      : pixel inside the (inclusive) box of an enabled sprite
//   off_x/off_y : pixel minus saturated top-left corner, truncated
// ---------------------------------------------------------------------------
module sprite_box_test #(
    parameter int COORD_W = 10
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] size,
    input  logic               en,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic               in_box,
    output logic [COORD_W-1:0] off_x,
    output logic [COORD_W-1:0] off_y
);

    // Lower edge centre-size, clamped at 0 instead of wrapping.
    function automatic logic [COORD_W:0] low_edge(
        input logic [COORD_W-1:0] c,
        input logic [COORD_W-1:0] s
    );
        logic [COORD_W:0] r;
        if (c >= s) begin
            r = {1'b0, c} - {1'b0, s};
        end else begin
            r = {(COORD_W+1){1'b0}};
        end
        return r;
    endfunction

    logic [COORD_W:0] lo_x_s;
    logic [COORD_W:0] lo_y_s;
    logic [COORD_W:0] hi_x_s;
    logic [COORD_W:0] hi_y_s;
    logic [COORD_W:0] px_e_s;
    logic [COORD_W:0] py_e_s;

    // Box edges and offsets, all bounds one bit wider than the screen.
    always_comb begin
        lo_x_s = low_edge(x, size);
        lo_y_s = low_edge(y, size);
        hi_x_s = {1'b0, x} + {1'b0, size};
        hi_y_s = {1'b0, y} + {1'b0, size};
        px_e_s = {1'b0, px};
        py_e_s = {1'b0, py};
        if (en && (px_e_s >= lo_x_s) && (px_e_s <= hi_x_s) &&
                  (py_e_s >= lo_y_s) && (py_e_s <= hi_y_s)) begin
            in_box = 1'b1;
        end else begin
            in_box = 1'b0;
        end
        off_x = px - lo_x_s[COORD_W-1:0];
        off_y = py - lo_y_s[COORD_W-1:0];
    end

endmodule

// File: rtl/sprite_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_scheduler
// Double-buffered sprite table with a 2-stage pixel hit pipeline.
// Updates land in a shadow bank during the vblank UPDATE window; the shadow
// bank is copied to the active bank when vblank falls. Every pixel is tested
// against the active bank; the lowest matching slot wins.
// Ports:
//   Clk, Reset         : clock, asynchronous active-low reset
//   frame_start, vblank: frame timing from the video controller
//   upd_*              : slot update request / handshake
//   DrawX, DrawY       : current pixel, qualified by pix_valid
//   out_valid, hit, hit_id, OffX, OffY : pixel result, 2 cycles later
// ---------------------------------------------------------------------------
module sprite_scheduler
    import game_pkg::*;
#(
    parameter int  NUM_SPRITES = NUM_SPRITES_DEF,
    parameter int  COORD_W     = COORD_W_DEF,
    localparam int ID_W        = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_start,
    input  logic               vblank,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [ID_W-1:0]    upd_id,
    input  logic [COORD_W-1:0] upd_x,
    input  logic [COORD_W-1:0] upd_y,
    input  logic [COORD_W-1:0] upd_size,
    input  logic               upd_en,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    input  logic               pix_valid,
    output logic               out_valid,
    output logic               hit,
    output logic [ID_W-1:0]    hit_id,
    output logic [COORD_W-1:0] OffX,
    output logic [COORD_W-1:0] OffY
);

    logic [1:0] state_q, state_d;

    logic [COORD_W-1:0] shd_x_q    [NUM_SPRITES];
    logic [COORD_W-1:0] shd_x_d    [NUM_SPRITES];
    logic [COORD_W-1:0] shd_y_q    [NUM_SPRITES];
    logic [COORD_W-1:0] shd_y_d    [NUM_SPRITES];
    logic [COORD_W-1:0] shd_size_q [NUM_SPRITES];
    logic [COORD_W-1:0] shd_size_d [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] shd_en_q, shd_en_d;

    logic [COORD_W-1:0] act_x_q    [NUM_SPRITES];
    logic [COORD_W-1:0] act_x_d    [NUM_SPRITES];
    logic [COORD_W-1:0] act_y_q    [NUM_SPRITES];
    logic [COORD_W-1:0] act_y_d    [NUM_SPRITES];
    logic [COORD_W-1:0] act_size_q [NUM_SPRITES];
    logic [COORD_W-1:0] act_size_d [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] act_en_q, act_en_d;

    logic [NUM_SPRITES-1:0] box_in_s;
    logic [COORD_W-1:0]     box_off_x_s [NUM_SPRITES];
    logic [COORD_W-1:0]     box_off_y_s [NUM_SPRITES];

    // Stage 1: pixel valid, per-slot in-box vector and per-slot pixel offsets.
    logic                   s1_valid_q, s1_valid_d;
    logic [NUM_SPRITES-1:0] s1_in_box_q, s1_in_box_d;
    logic [COORD_W-1:0]     s1_off_x_q [NUM_SPRITES];
    logic [COORD_W-1:0]     s1_off_x_d [NUM_SPRITES];
    logic [COORD_W-1:0]     s1_off_y_q [NUM_SPRITES];
    logic [COORD_W-1:0]     s1_off_y_d [NUM_SPRITES];

    // Stage 2: priority-encoded result.
    logic               out_valid_q, out_valid_d;
    logic               hit_q, hit_d;
    logic [ID_W-1:0]    hit_id_q, hit_id_d;
    logic [COORD_W-1:0] off_x_q, off_x_d;
    logic [COORD_W-1:0] off_y_q, off_y_d;

    logic               win_found_s;
    logic [ID_W-1:0]    win_id_s;
    logic [COORD_W-1:0] win_off_x_s;
    logic [COORD_W-1:0] win_off_y_s;

    logic accept_s;
    logic commit_s;

    assign upd_ready = (state_q == ST_UPDATE) && vblank;
    assign accept_s  = upd_valid && upd_ready;
    // The only cycle the active bank may change: UPDATE with vblank low.
    assign commit_s  = (state_q == ST_UPDATE) && !vblank;

    assign out_valid = out_valid_q;
    assign hit       = hit_q;
    assign hit_id    = hit_id_q;
    assign OffX      = off_x_q;
    assign OffY      = off_y_q;

    // Frame FSM next-state; frame_start during UPDATE is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) state_d = ST_UPDATE;
                else             state_d = ST_IDLE;
            end
            ST_UPDATE: begin
                if (!vblank) state_d = ST_DISPLAY;
                else         state_d = ST_UPDATE;
            end
            ST_DISPLAY: begin
                if (frame_start) state_d = ST_UPDATE;
                else             state_d = ST_DISPLAY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow bank write: one slot per accepted update, last write wins.
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (accept_s && (upd_id == ID_W'(i))) begin
                shd_x_d[i]    = upd_x;
                shd_y_d[i]    = upd_y;
                shd_size_d[i] = upd_size;
                shd_en_d[i]   = upd_en;
            end else begin
                shd_x_d[i]    = shd_x_q[i];
                shd_y_d[i]    = shd_y_q[i];
                shd_size_d[i] = shd_size_q[i];
                shd_en_d[i]   = shd_en_q[i];
            end
        end
    end

    // Active bank: whole-bank copy from shadow on the commit cycle.
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (commit_s) begin
                act_x_d[i]    = shd_x_q[i];
                act_y_d[i]    = shd_y_q[i];
                act_size_d[i] = shd_size_q[i];
                act_en_d[i]   = shd_en_q[i];
            end else begin
                act_x_d[i]    = act_x_q[i];
                act_y_d[i]    = act_y_q[i];
                act_size_d[i] = act_size_q[i];
                act_en_d[i]   = act_en_q[i];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SPRITES; g++) begin : g_box
            sprite_box_test #(
                .COORD_W (COORD_W)
            ) u_box (
                .x      (act_x_q[g]),
                .y      (act_y_q[g]),
                .size   (act_size_q[g]),
                .en     (act_en_q[g]),
                .px     (DrawX),
                .py     (DrawY),
                .in_box (box_in_s[g]),
                .off_x  (box_off_x_s[g]),
                .off_y  (box_off_y_s[g])
            );
        end
    endgenerate

    // Stage 1 capture; data is zeroed for invalid pixels so stale hits never leak.
    always_comb begin
        s1_valid_d = pix_valid;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (pix_valid) begin
                s1_in_box_d[i] = box_in_s[i];
                s1_off_x_d[i]  = box_off_x_s[i];
                s1_off_y_d[i]  = box_off_y_s[i];
            end else begin
                s1_in_box_d[i] = 1'b0;
                s1_off_x_d[i]  = {COORD_W{1'b0}};
                s1_off_y_d[i]  = {COORD_W{1'b0}};
            end
        end
    end

    // Priority encoder: scan high to low so the lowest matching slot wins.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = {ID_W{1'b0}};
        win_off_x_s = {COORD_W{1'b0}};
        win_off_y_s = {COORD_W{1'b0}};
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (s1_in_box_q[i]) begin
                win_found_s = 1'b1;
                win_id_s    = ID_W'(i);
                win_off_x_s = s1_off_x_q[i];
                win_off_y_s = s1_off_y_q[i];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Stage 2 result; all fields held at zero unless a valid pixel hit.
    always_comb begin
        out_valid_d = s1_valid_q;
        if (s1_valid_q && win_found_s) begin
            hit_d    = 1'b1;
            hit_id_d = win_id_s;
            off_x_d  = win_off_x_s;
            off_y_d  = win_off_y_s;
        end else begin
            hit_d    = 1'b0;
            hit_id_d = {ID_W{1'b0}};
            off_x_d  = {COORD_W{1'b0}};
            off_y_d  = {COORD_W{1'b0}};
        end
    end

    // All state flops; reset clears both banks and the whole pixel pipeline.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            shd_en_q    <= {NUM_SPRITES{1'b0}};
            act_en_q    <= {NUM_SPRITES{1'b0}};
            s1_valid_q  <= 1'b0;
            s1_in_box_q <= {NUM_SPRITES{1'b0}};
            out_valid_q <= 1'b0;
            hit_q       <= 1'b0;
            hit_id_q    <= {ID_W{1'b0}};
            off_x_q     <= {COORD_W{1'b0}};
            off_y_q     <= {COORD_W{1'b0}};
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shd_x_q[i]    <= {COORD_W{1'b0}};
                shd_y_q[i]    <= {COORD_W{1'b0}};
                shd_size_q[i] <= {COORD_W{1'b0}};
                act_x_q[i]    <= {COORD_W{1'b0}};
                act_y_q[i]    <= {COORD_W{1'b0}};
                act_size_q[i] <= {COORD_W{1'b0}};
                s1_off_x_q[i] <= {COORD_W{1'b0}};
                s1_off_y_q[i] <= {COORD_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            shd_en_q    <= shd_en_d;
            act_en_q    <= act_en_d;
            s1_valid_q  <= s1_valid_d;
            s1_in_box_q <= s1_in_box_d;
            out_valid_q <= out_valid_d;
            hit_q       <= hit_d;
            hit_id_q    <= hit_id_d;
            off_x_q     <= off_x_d;
            off_y_q     <= off_y_d;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shd_x_q[i]    <= shd_x_d[i];
                shd_y_q[i]    <= shd_y_d[i];
                shd_size_q[i] <= shd_size_d[i];
                act_x_q[i]    <= act_x_d[i];
                act_y_q[i]    <= act_y_d[i];
                act_size_q[i] <= act_size_d[i];
                s1_off_x_q[i] <= s1_off_x_d[i];
                s1_off_y_q[i] <= s1_off_y_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sprite_scheduler
// Directed stimulus with hand-computed expectations. Each issued pixel pushes
// its expected result (and the cycle it must appear in) into a scoreboard;
// an independent negedge monitor pops and compares whenever out_valid is high
// and checks that outputs stay zero otherwise.
// ---------------------------------------------------------------------------
module tb_sprite_scheduler;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_start;
    logic       vblank;
    logic       upd_valid;
    logic       upd_ready;
    logic [1:0] upd_id;
    logic [9:0] upd_x;
    logic [9:0] upd_y;
    logic [9:0] upd_size;
    logic       upd_en;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       pix_valid;
    logic       out_valid;
    logic       hit;
    logic [1:0] hit_id;
    logic [9:0] OffX;
    logic [9:0] OffY;

    sprite_scheduler dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .vblank      (vblank),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_id      (upd_id),
        .upd_x       (upd_x),
        .upd_y       (upd_y),
        .upd_size    (upd_size),
        .upd_en      (upd_en),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .pix_valid   (pix_valid),
        .out_valid   (out_valid),
        .hit         (hit),
        .hit_id      (hit_id),
        .OffX        (OffX),
        .OffY        (OffY)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        int         due;
        logic       hit;
        logic [1:0] id;
        logic [9:0] ox;
        logic [9:0] oy;
        string      tag;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Issue one valid pixel and queue its expected result two cycles later.
    task automatic pixel(input string tag, input int x, input int y, input logic h,
                         input logic [1:0] id, input int ox, input int oy);
        exp_t e;
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        pix_valid = 1'b1;
        e.due = cyc + 2;
        e.hit = h;
        e.id  = id;
        e.ox  = 10'(ox);
        e.oy  = 10'(oy);
        e.tag = tag;
        sb.push_back(e);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic miss(input string tag, input int x, input int y);
        pixel(tag, x, y, 1'b0, 2'd0, 0, 0);
    endtask

    task automatic frame_begin;
        frame_start = 1'b1;
        vblank      = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("upd_ready_in_update", {31'd0, upd_ready}, 32'd1);
    endtask

    task automatic write_slot(input logic [1:0] id, input int x, input int y,
                              input int s, input logic en);
        upd_valid = 1'b1;
        upd_id    = id;
        upd_x     = 10'(x);
        upd_y     = 10'(y);
        upd_size  = 10'(s);
        upd_en    = en;
        #1;
        chk("upd_ready_on_write", {31'd0, upd_ready}, 32'd1);
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic frame_end;
        vblank = 1'b0;
        tick();
        chk("upd_ready_display", {31'd0, upd_ready}, 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_upd_ready"}, {31'd0, upd_ready}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_hit"},       {31'd0, hit},       32'd0);
        chk({tag, "_hit_id"},    {30'd0, hit_id},    32'd0);
        chk({tag, "_OffX"},      {22'd0, OffX},      32'd0);
        chk({tag, "_OffY"},      {22'd0, OffY},      32'd0);
    endtask

    // Scoreboard monitor: compare on every valid output, zero-check otherwise.
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (Reset === 1'b1) begin
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_out: out_valid=1 with empty scoreboard at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, "_cycle"}, cyc, e.due);
                    chk({e.tag, "_hit"},   {31'd0, hit},    {31'd0, e.hit});
                    chk({e.tag, "_id"},    {30'd0, hit_id}, {30'd0, e.id});
                    chk({e.tag, "_OffX"},  {22'd0, OffX},   {22'd0, e.ox});
                    chk({e.tag, "_OffY"},  {22'd0, OffY},   {22'd0, e.oy});
                end
            end else begin
                chk("idle_outputs_zero", {9'd0, hit, hit_id, OffX, OffY}, 32'd0);
            end
        end
    end

    initial begin
        Reset       = 1'b0;
        frame_start = 1'b0;
        vblank      = 1'b0;
        upd_valid   = 1'b0;
        upd_id      = 2'd0;
        upd_x       = 10'd0;
        upd_y       = 10'd0;
        upd_size    = 10'd0;
        upd_en      = 1'b0;
        DrawX       = 10'd0;
        DrawY       = 10'd0;
        pix_valid   = 1'b0;
        repeat (3) tick();
        check_zero_outputs("reset");
        Reset = 1'b1;
        tick();

        // IDLE: no handshake even with vblank high; all slots disabled.
        vblank = 1'b1;
        #1;
        chk("idle_upd_ready", {31'd0, upd_ready}, 32'd0);
        vblank = 1'b0;
        miss("idle_miss", 92, 192);

        // Single doodler, inclusive edges.
        frame_begin();
        write_slot(2'd0, 100, 200, 8, 1'b1);
        frame_end();
        pixel("doodler_corner", 92, 192, 1'b1, 2'd0, 0, 0);
        miss("doodler_x_past", 109, 200);
        pixel("doodler_far_edge", 108, 208, 1'b1, 2'd0, 16, 16);
        miss("doodler_x_before", 91, 200);

        // Overlap: lowest slot wins.
        frame_begin();
        write_slot(2'd0, 100, 100, 8, 1'b1);
        write_slot(2'd2, 104, 104, 8, 1'b1);
        frame_end();
        pixel("overlap", 106, 106, 1'b1, 2'd0, 14, 14);
        pixel("slot2_only", 112, 112, 1'b1, 2'd2, 16, 16);
        miss("slot2_past", 113, 104);

        // Saturated low edge, disabled slot, pix_valid 1,0,1.
        frame_begin();
        write_slot(2'd1, 3, 50, 8, 1'b1);
        write_slot(2'd0, 100, 100, 8, 1'b0);
        frame_end();
        pixel("sat_low", 0, 50, 1'b1, 2'd1, 0, 8);
        tick();
        pixel("sat_high", 11, 58, 1'b1, 2'd1, 11, 16);
        miss("sat_past", 12, 50);
        pixel("slot0_disabled", 100, 100, 1'b1, 2'd2, 4, 4);

        // Update attempt during DISPLAY is refused.
        upd_valid = 1'b1;
        upd_id    = 2'd3;
        upd_x     = 10'd700;
        upd_y     = 10'd700;
        upd_size  = 10'd8;
        upd_en    = 1'b1;
        #1;
        chk("display_upd_ready", {31'd0, upd_ready}, 32'd0);
        tick();
        upd_valid = 1'b0;
        pixel("display_unchanged", 0, 50, 1'b1, 2'd1, 0, 8);

        // Two writes to one slot; active bank only changes after vblank falls.
        frame_begin();
        pixel("update_old_bank", 0, 50, 1'b1, 2'd1, 0, 8);
        write_slot(2'd1, 300, 300, 8, 1'b1);
        write_slot(2'd1, 500, 500, 4, 1'b1);
        miss("pre_commit", 500, 500);
        frame_end();
        pixel("last_write", 500, 500, 1'b1, 2'd1, 4, 4);
        miss("first_write_gone", 300, 300);
        miss("display_write_dropped", 700, 700);
        miss("old_slot1_gone", 0, 50);
        pixel("slot2_kept", 104, 104, 1'b1, 2'd2, 8, 8);
        repeat (4) tick();

        // Reset mid-UPDATE with a pending write and an in-flight pixel.
        frame_begin();
        DrawX     = 10'd500;
        DrawY     = 10'd500;
        pix_valid = 1'b1;
        tick();
        pix_valid = 1'b0;
        upd_valid = 1'b1;
        upd_id    = 2'd0;
        upd_x     = 10'd200;
        upd_y     = 10'd200;
        upd_size  = 10'd8;
        upd_en    = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        upd_valid = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        #1;
        chk("post_reset_idle_ready", {31'd0, upd_ready}, 32'd0);
        miss("post_reset_old", 500, 500);
        miss("post_reset_pending", 200, 200);
        frame_begin();
        frame_end();
        miss("post_commit_old", 500, 500);
        miss("post_commit_pending", 200, 200);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain: %0d expected results never appeared, expected 0 left", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
